// File: rtl/sseg_scan_sched_if.sv
// Producer-side write/commit port of the seven-segment scan scheduler.
interface sseg_scan_sched_if;
    logic       wr_valid;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       commit;
    logic       commit_done;

    modport master (
        output wr_valid, wr_addr, wr_data, commit,
        input  wr_ready, commit_done
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, commit,
        output wr_ready, commit_done
    );
endinterface

// File: rtl/sseg_scan_sched.sv
// Time-multiplexed 3-digit seven-segment scan scheduler with shadow/active
// double buffering, inter-digit blanking and 4-bit PWM brightness.
module sseg_scan_sched #(
    parameter int unsigned SCAN_DIV  = 65536,
    parameter int unsigned BLANK_CYC = 256,
    parameter logic [7:0]  SEG_OFF   = 8'hFF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hold,
    input  logic [3:0]         bright,
    sseg_scan_sched_if.slave   bus,
    output logic               frame_tick,
    output logic [7:0]         sseg,
    output logic [2:0]         en
);

    localparam int unsigned   CW        = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);

    typedef enum logic {S_BLANK, S_ON}  scan_state_t;
    typedef enum logic {C_IDLE, C_PEND} commit_state_t;

    scan_state_t     state_q, state_d;
    commit_state_t   cst_q, cst_d;
    logic [CW-1:0]   slot_q, slot_d;
    logic [1:0]      digit_q, digit_d;
    logic [2:0]      en_q, en_d;
    logic [7:0]      sseg_q, sseg_d;
    logic            rdy_q, rdy_d;
    logic [2:0][7:0] shadow_q, shadow_d;
    logic [2:0][7:0] active_q, active_d;
    logic            done_c;
    logic            tick_c;
    logic            wrap_c;
    logic            lit_c;

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_BLANK;
            cst_q    <= C_IDLE;
            slot_q   <= '0;
            digit_q  <= 2'd0;
            en_q     <= 3'b111;
            sseg_q   <= SEG_OFF;
            rdy_q    <= 1'b1;
            shadow_q <= {3{SEG_OFF}};
            active_q <= {3{SEG_OFF}};
        end else begin
            state_q  <= state_d;
            cst_q    <= cst_d;
            slot_q   <= slot_d;
            digit_q  <= digit_d;
            en_q     <= en_d;
            sseg_q   <= sseg_d;
            rdy_q    <= rdy_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    // Next-state: scan counter, output drive, write port and commit FSM
    always_comb begin
        state_d  = state_q;
        cst_d    = cst_q;
        slot_d   = slot_q;
        digit_d  = digit_q;
        en_d     = en_q;
        sseg_d   = sseg_q;
        shadow_d = shadow_q;
        active_d = active_q;
        done_c   = 1'b0;

        wrap_c = (slot_q == CNT_LAST);
        tick_c = !hold && wrap_c && (digit_q == 2'd2);
        lit_c  = (state_q == S_ON) && (slot_q[3:0] < bright);

        if (!hold) begin
            if (wrap_c) begin
                slot_d  = '0;
                digit_d = (digit_q == 2'd2) ? 2'd0 : digit_q + 2'd1;
            end else begin
                slot_d = slot_q + CW'(1);
            end
            state_d = (slot_d < CNT_BLANK) ? S_BLANK : S_ON;

            if (lit_c) begin
                case (digit_q)
                    2'd0:    begin en_d = 3'b110; sseg_d = active_q[0]; end
                    2'd1:    begin en_d = 3'b101; sseg_d = active_q[1]; end
                    default: begin en_d = 3'b011; sseg_d = active_q[2]; end
                endcase
            end else begin
                en_d   = 3'b111;
                sseg_d = SEG_OFF;
            end
        end

        // Address 3 is accepted but discarded
        if (bus.wr_valid && rdy_q) begin
            case (bus.wr_addr)
                2'd0:    shadow_d[0] = bus.wr_data;
                2'd1:    shadow_d[1] = bus.wr_data;
                2'd2:    shadow_d[2] = bus.wr_data;
                default: ;
            endcase
        end

        // Publish only on the frame boundary so active never tears mid-frame
        case (cst_q)
            C_IDLE: begin
                if (bus.commit) cst_d = C_PEND;
            end
            C_PEND: begin
                if (tick_c) begin
                    active_d = shadow_q;
                    done_c   = 1'b1;
                    cst_d    = C_IDLE;
                end
            end
            default: cst_d = C_IDLE;
        endcase

        rdy_d = (cst_d == C_IDLE);
    end

    assign bus.wr_ready    = rdy_q;
    assign bus.commit_done = done_c;
    assign frame_tick      = tick_c;
    assign sseg            = sseg_q;
    assign en              = en_q;

endmodule

// File: tb/tb_sseg_scan_sched.sv
// Directed self-checking bench for sseg_scan_sched (SCAN_DIV=64, BLANK_CYC=16).
module tb_sseg_scan_sched;

    localparam int unsigned SD = 64;
    localparam int unsigned BC = 16;
    localparam int          FR = 192;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       hold;
    logic [3:0] bright;
    logic       frame_tick;
    logic [7:0] sseg;
    logic [2:0] en;

    sseg_scan_sched_if bus();

    sseg_scan_sched #(.SCAN_DIV(SD), .BLANK_CYC(BC), .SEG_OFF(8'hFF)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hold       (hold),
        .bright     (bright),
        .bus        (bus),
        .frame_tick (frame_tick),
        .sseg       (sseg),
        .en         (en)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] bright;
        int         pos;
        logic [2:0] en;
        logic [7:0] sseg;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;   // unfrozen clock edges since reset release

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        logic h;
        h = hold;
        @(posedge clk);
        if (!h) cyc++;
        #1;
    endtask

    task automatic advance_to(input int pos);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (((cyc % FR) != pos) && (k < 400));
    endtask

    task automatic check_at(input string nm, input int pos, input logic [2:0] e_en, input logic [7:0] e_ss);
        advance_to(pos);
        chk({nm, ".en"},   32'(en),   32'(e_en));
        chk({nm, ".sseg"}, 32'(sseg), 32'(e_ss));
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = a;
        bus.wr_data  = d;
        chk("wr.ready", 32'(bus.wr_ready), 1);
        tick();
        bus.wr_valid = 1'b0;
    endtask

    task automatic do_commit();
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
    endtask

    // Waits for commit_done; meanwhile the display must keep showing the old active buffer
    task automatic wait_done(input string nm, input logic [7:0] o0, input logic [7:0] o1, input logic [7:0] o2);
        bit seen;
        bit torn;
        seen = 1'b0;
        torn = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (bus.commit_done) begin
                seen = 1'b1;
                break;
            end
            case (en)
                3'b110:  if (sseg !== o0) torn = 1'b1;
                3'b101:  if (sseg !== o1) torn = 1'b1;
                3'b011:  if (sseg !== o2) torn = 1'b1;
                default: ;
            endcase
            tick();
        end
        chk({nm, ".done_seen"}, 32'(seen), 1);
        chk({nm, ".done_tick"}, 32'(frame_tick), 1);
        chk({nm, ".done_pos"},  32'(cyc % FR), 32'(FR - 1));
        chk({nm, ".no_tear"},   32'(torn), 0);
        tick();
        chk({nm, ".ready_back"}, 32'(bus.wr_ready), 1);
    endtask

    vec_t vecs [17];
    int   lit_n;
    bit   moved;
    bit   ft_seen;

    initial begin
        vecs[0]  = '{4'd15, 16,  3'b111, 8'hFF};
        vecs[1]  = '{4'd15, 17,  3'b110, 8'h3F};
        vecs[2]  = '{4'd15, 63,  3'b110, 8'h3F};
        vecs[3]  = '{4'd15, 64,  3'b111, 8'hFF};
        vecs[4]  = '{4'd15, 65,  3'b111, 8'hFF};
        vecs[5]  = '{4'd15, 81,  3'b101, 8'h06};
        vecs[6]  = '{4'd15, 145, 3'b011, 8'h5B};
        vecs[7]  = '{4'd15, 0,   3'b111, 8'hFF};
        vecs[8]  = '{4'd4,  17,  3'b110, 8'h3F};
        vecs[9]  = '{4'd4,  20,  3'b110, 8'h3F};
        vecs[10] = '{4'd4,  21,  3'b111, 8'hFF};
        vecs[11] = '{4'd4,  33,  3'b110, 8'h3F};
        vecs[12] = '{4'd4,  100, 3'b101, 8'h06};
        vecs[13] = '{4'd4,  101, 3'b111, 8'hFF};
        vecs[14] = '{4'd4,  177, 3'b011, 8'h5B};
        vecs[15] = '{4'd4,  180, 3'b011, 8'h5B};
        vecs[16] = '{4'd4,  181, 3'b111, 8'hFF};

        rst_n        = 1'b0;
        hold         = 1'b0;
        bright       = 4'd15;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = 2'd0;
        bus.wr_data  = 8'h00;
        bus.commit   = 1'b0;

        // Reset values
        @(posedge clk); #1;
        chk("rst.en",          32'(en), 32'h7);
        chk("rst.sseg",        32'(sseg), 32'hFF);
        chk("rst.wr_ready",    32'(bus.wr_ready), 1);
        chk("rst.commit_done", 32'(bus.commit_done), 0);
        chk("rst.frame_tick",  32'(frame_tick), 0);
        tick();
        rst_n = 1'b1;
        cyc   = 0;

        // First lit clock after the blanking gap
        check_at("t1.blank", 16, 3'b111, 8'hFF);
        check_at("t1.first", 17, 3'b110, 8'hFF);

        // Load shadow and commit
        wr(2'd0, 8'h3F);
        wr(2'd1, 8'h06);
        wr(2'd2, 8'h5B);
        do_commit();
        chk("t2.ready_low", 32'(bus.wr_ready), 0);
        wait_done("t2", 8'hFF, 8'hFF, 8'hFF);

        // Scan pattern and PWM windows
        foreach (vecs[i]) begin
            bright = vecs[i].bright;
            check_at($sformatf("vec%0d", i), vecs[i].pos, vecs[i].en, vecs[i].sseg);
        end

        // Lit clock count per frame for bright=4 and bright=0
        advance_to(0);
        lit_n = 0;
        for (int i = 0; i < FR; i++) begin
            tick();
            if (en !== 3'b111) lit_n++;
        end
        chk("t3.lit_b4", 32'(lit_n), 36);
        bright = 4'd0;
        lit_n  = 0;
        for (int i = 0; i < FR; i++) begin
            tick();
            if (en !== 3'b111) lit_n++;
        end
        chk("t3.lit_b0", 32'(lit_n), 0);

        // Freeze inside the digit-1 lit window
        bright = 4'd15;
        check_at("t4.pre", 90, 3'b101, 8'h06);
        hold    = 1'b1;
        moved   = 1'b0;
        ft_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (en !== 3'b101 || sseg !== 8'h06) moved = 1'b1;
            if (frame_tick) ft_seen = 1'b1;
        end
        chk("t4.frozen", 32'(moved), 0);
        chk("t4.no_tick", 32'(ft_seen), 0);
        hold = 1'b0;
        tick();
        chk("t4.resume.en",   32'(en), 32'h5);
        chk("t4.resume.sseg", 32'(sseg), 32'h06);
        advance_to(FR - 1);
        chk("t4.resume.tick", 32'(frame_tick), 1);

        // Discarded write to address 3
        wr(2'd3, 8'h00);
        do_commit();
        wait_done("t5", 8'h3F, 8'h06, 8'h5B);
        check_at("t5.d0", 17,  3'b110, 8'h3F);
        check_at("t5.d1", 81,  3'b101, 8'h06);
        check_at("t5.d2", 145, 3'b011, 8'h5B);

        // Reset with a commit pending
        advance_to(100);
        do_commit();
        chk("t6.ready_low", 32'(bus.wr_ready), 0);
        chk("t6.lit_before", 32'(en), 32'h5);
        #2 rst_n = 1'b0;
        #1;
        chk("t6.rst.en",       32'(en), 32'h7);
        chk("t6.rst.sseg",     32'(sseg), 32'hFF);
        chk("t6.rst.wr_ready", 32'(bus.wr_ready), 1);
        tick();
        rst_n = 1'b1;
        cyc   = 0;
        chk("t6.ready", 32'(bus.wr_ready), 1);
        check_at("t6.buf_reset", 17, 3'b110, 8'hFF);
        advance_to(FR - 1);
        chk("t6.tick",    32'(frame_tick), 1);
        chk("t6.no_done", 32'(bus.commit_done), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
